// File: rtl/toff_stim_chk.sv
// toff_stim_chk: self-test harness for a 3-bit Toffoli gate.
// Sweeps all 8 {a,b,c} vectors into the gate PASSES times, holds each vector
// for SETTLE cycles, then samples the gate outputs in a single CHECK cycle and
// compares them with the Toffoli truth function.
// Optional macro TOFF_PERM_CHK_EN adds a bijectivity check over the first pass.

module toff_stim_chk #(
    parameter int unsigned PASSES = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_drv,
    output logic       b_drv,
    output logic       c_drv,
    input  logic       a_ret,
    input  logic       b_ret,
    input  logic       c_ret,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);
    localparam logic [3:0] ERR_MAX     = 4'd15;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] vec;
    logic [3:0] pass_cnt;
    logic [3:0] settle_cnt;

    logic [2:0] ret;
    logic [2:0] expected;
    logic       mismatch;
    logic       accept;
    logic       settle_last;
    logic       vec_last;
    logic       pass_last;
    logic       perm_ok;

    // Gate response and its reference; only meaningful during CHECK.
    assign ret         = {a_ret, b_ret, c_ret};
    assign expected    = {vec[2], vec[1], vec[0] ^ (vec[2] & vec[1])};
    assign mismatch    = (ret != expected);

    // A start is only honoured when no sweep is running.
    assign accept      = start && ((state == S_IDLE) || (state == S_FIN));
    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign vec_last    = (vec == 3'd7);
    assign pass_last   = (pass_cnt == PASS_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: SETTLE for SETTLE cycles, one CHECK, repeat per vector.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_last) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (vec_last && pass_last) ? S_FIN : S_SETTLE;
            S_FIN:    if (start) state_nxt = S_SETTLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Sweep sequencing: settle timer, vector index and pass index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= 3'd0;
            pass_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
        end else if (accept) begin
            vec        <= 3'd0;
            pass_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
        end else begin
            case (state)
                S_SETTLE: begin
                    settle_cnt <= settle_last ? 4'd0 : settle_cnt + 4'd1;
                end
                S_CHECK: begin
                    // vec wraps 7 -> 0 naturally; the pass index advances on the wrap.
                    vec <= vec + 3'd1;
                    if (vec_last && !pass_last) begin
                        pass_cnt <= pass_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result accumulation: saturating error count and first failing vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= 4'd0;
            fail_vec <= 3'd0;
        end else if (accept) begin
            err_cnt  <= 4'd0;
            fail_vec <= 3'd0;
        end else if ((state == S_CHECK) && mismatch) begin
            // A zero count means this is the first mismatch of the run.
            if (err_cnt == 4'd0) begin
                fail_vec <= vec;
            end
            if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 4'd1;
            end
        end
    end

`ifdef TOFF_PERM_CHK_EN
    logic [7:0] seen;
    logic       dup;

    // First-pass bitmap of returned triples; a repeat means the gate is not bijective.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= 8'h00;
            dup  <= 1'b0;
        end else if (accept) begin
            seen <= 8'h00;
            dup  <= 1'b0;
        end else if ((state == S_CHECK) && (pass_cnt == 4'd0)) begin
            if (seen[ret]) begin
                dup <= 1'b1;
            end
            seen[ret] <= 1'b1;
        end
    end

    assign perm_ok = (seen == 8'hFF) && !dup;
`else
    assign perm_ok = 1'b1;
`endif

    // Moore outputs: drive the current vector while sweeping, report in FIN.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        a_drv = 1'b0;
        b_drv = 1'b0;
        c_drv = 1'b0;
        case (state)
            S_SETTLE, S_CHECK: begin
                busy                  = 1'b1;
                {a_drv, b_drv, c_drv} = vec;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: ;
        endcase
        pass = done && (err_cnt == 4'd0) && perm_ok;
    end

endmodule
